// File: rtl/pwm_sine_pkg.sv
// Shared types and constants for the PWM sine sequencer.
package pwm_sine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } seq_state_t;

    // sample * gain is renormalised by this many bits to form the duty value
    localparam int GAIN_SHIFT = 6;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter; flags the last cycle of each period.
module pwm_period_counter #(
    parameter int PWM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PWM_W-1:0] cnt,
    output logic             period_tick
);

    logic [PWM_W-1:0] r_cnt;

    // Count every clock, wrapping at 2^PWM_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= r_cnt + PWM_W'(1);
    end

    assign cnt         = r_cnt;
    assign period_tick = &r_cnt;

endmodule

// File: rtl/pwm_sine_sequencer.sv
// Sine-modulated PWM generator with soft start/stop gain ramps.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | output off, duty held at 0
// ST_RAMP_UP   | gain rises by 1 per period until it reaches amp
// ST_RUN       | gain tracks amp, one period of latency
// ST_RAMP_DOWN | gain falls by 1 per period; at 0 the phase is cleared
//
// Per period: cnt==0 reads the LUT, cnt==1 captures the sample,
// cnt==2 scales it, and the last cycle commits duty, phase and state.
module pwm_sine_sequencer
    import pwm_sine_pkg::*;
#(
    parameter int PWM_W  = 10,
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ACC_W-1:0]  phase_step,
    input  logic [7:0]        amp,
    output logic              lut_rd,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [7:0]        lut_data,
    output logic [PWM_W-1:0]  duty,
    output logic              period_tick,
    output logic              busy,
    output logic              pwm_out
);

    localparam logic [PWM_W-1:0] CNT_SAMPLE = PWM_W'(1);
    localparam logic [PWM_W-1:0] CNT_SCALE  = PWM_W'(2);

    logic [PWM_W-1:0] w_cnt;
    logic             w_tick;
    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [7:0]       r_gain;
    logic [7:0]       w_gain_next;
    logic [8:0]       w_gain_inc;
    logic             w_enter_idle;
    logic [15:0]      w_product;
    logic [ACC_W-1:0] r_phase_acc;
    logic [ACC_W-1:0] r_step;
    logic [7:0]       r_sample;
    logic [PWM_W-1:0] r_duty_next;
    logic [PWM_W-1:0] r_duty;
    logic             r_pwm;

    pwm_period_counter #(.PWM_W(PWM_W)) u_period_counter (
        .clk         (clk),
        .rst         (rst),
        .cnt         (w_cnt),
        .period_tick (w_tick)
    );

    assign w_gain_inc = {1'b0, r_gain} + 9'd1;

    // Next state and gain; both only move on the period boundary.
    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) w_state_next = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (stop) begin
                        w_state_next = ST_RAMP_DOWN;
                    end else if (w_gain_inc >= {1'b0, amp}) begin
                        w_gain_next  = amp;
                        w_state_next = ST_RUN;
                    end else begin
                        w_gain_next = w_gain_inc[7:0];
                    end
                end
                ST_RUN: begin
                    if (stop) w_state_next = ST_RAMP_DOWN;
                    else      w_gain_next  = amp;
                end
                ST_RAMP_DOWN: begin
                    if (start && !stop) begin
                        w_state_next = ST_RAMP_UP;
                    end else if (r_gain <= 8'd1) begin
                        w_gain_next  = 8'd0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_gain_next = r_gain - 8'd1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_enter_idle = w_tick && (r_state == ST_RAMP_DOWN) && (w_state_next == ST_IDLE);

    // State and gain registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gain  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_gain  <= w_gain_next;
        end
    end

    assign w_product = 16'(r_sample) * 16'(r_gain);

    // Sample pipeline, double-buffered duty, phase accumulator and PWM compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase_acc <= '0;
            r_step      <= '0;
            r_sample    <= 8'd0;
            r_duty_next <= '0;
            r_duty      <= '0;
            r_pwm       <= 1'b0;
        end else begin
            if (w_cnt == CNT_SAMPLE) r_sample    <= lut_data;
            if (w_cnt == CNT_SCALE)  r_duty_next <= PWM_W'(w_product >> GAIN_SHIFT);
            if (w_tick) begin
                r_duty      <= (w_state_next == ST_IDLE) ? '0 : r_duty_next;
                r_phase_acc <= w_enter_idle ? '0 : r_phase_acc + r_step;
                r_step      <= phase_step;
            end
            r_pwm <= (r_state != ST_IDLE) && (w_cnt < r_duty);
        end
    end

    // The read strobe is decoded from cnt, so it is masked while reset holds cnt at 0.
    assign lut_rd      = (w_cnt == '0) && !rst;
    assign lut_addr    = r_phase_acc[ACC_W-1 -: LUT_AW];
    assign duty        = r_duty;
    assign period_tick = w_tick;
    assign busy        = (r_state != ST_IDLE);
    assign pwm_out     = r_pwm;

endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// Self-checking bench for pwm_sine_sequencer with a period-level reference model.
module tb_pwm_sine_sequencer;

    localparam int MAXC = 1023;
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_UP   = 2'd1;
    localparam logic [1:0] M_RUN  = 2'd2;
    localparam logic [1:0] M_DOWN = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] phase_step = 32'd0;
    logic [7:0]  amp = 8'd0;
    logic        lut_rd;
    logic [7:0]  lut_addr;
    logic [7:0]  lut_data = 8'd0;
    logic [9:0]  duty;
    logic        period_tick;
    logic        busy;
    logic        pwm_out;

    logic [7:0]  lut_mem [256];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;

    typedef struct packed {
        logic [9:0]  cnt;
        logic [1:0]  mode;
        logic [7:0]  gain;
        logic [31:0] phase;
        logic [31:0] step;
        logic [7:0]  samp;
        logic [9:0]  duty;
        logic        pwm;
    } mdl_t;

    mdl_t m = '0;

    pwm_sine_sequencer #(.PWM_W(10), .ACC_W(32), .LUT_AW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .phase_step  (phase_step),
        .amp         (amp),
        .lut_rd      (lut_rd),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .duty        (duty),
        .period_tick (period_tick),
        .busy        (busy),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    // External LUT: data valid the cycle after the read strobe.
    always @(posedge clk) if (lut_rd) lut_data <= lut_mem[lut_addr];

    // One clock of the reference: the period-level rules applied on the last count.
    function automatic mdl_t model_step(mdl_t s, logic st, logic sp, logic [7:0] a, logic [31:0] ps);
        mdl_t n;
        int g;
        logic [1:0] md;
        n = s;
        n.pwm = (s.mode != M_IDLE) && (s.cnt < s.duty);
        if (s.cnt == 10'd0) n.samp = lut_mem[s.phase[31:24]];
        if (s.cnt == 10'(MAXC)) begin
            g  = int'(s.gain);
            md = s.mode;
            case (s.mode)
                M_IDLE: if (st && !sp) md = M_UP;
                M_UP: begin
                    if (sp) md = M_DOWN;
                    else if (g + 1 >= int'(a)) begin g = int'(a); md = M_RUN; end
                    else g = g + 1;
                end
                M_RUN: begin
                    if (sp) md = M_DOWN;
                    else g = int'(a);
                end
                default: begin
                    if (st && !sp) md = M_UP;
                    else if (g <= 1) begin g = 0; md = M_IDLE; end
                    else g = g - 1;
                end
            endcase
            n.duty  = (md == M_IDLE) ? 10'd0 : 10'((int'(s.samp) * int'(s.gain)) / 64);
            n.phase = (s.mode == M_DOWN && md == M_IDLE) ? 32'd0 : s.phase + s.step;
            n.step  = ps;
            n.gain  = 8'(g);
            n.mode  = md;
        end
        n.cnt = s.cnt + 10'd1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_step(m, start, stop, amp, phase_step);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("duty",        32'(duty),        32'(m.duty));
            chk("busy",        32'(busy),        32'(m.mode != M_IDLE));
            chk("period_tick", 32'(period_tick), 32'(m.cnt == 10'(MAXC)));
            chk("lut_rd",      32'(lut_rd),      32'((m.cnt == 10'd0) && !rst));
            chk("lut_addr",    32'(lut_addr),    32'(m.phase[31:24]));
            chk("pwm_out",     32'(pwm_out),     32'(m.pwm));
        end
    end

    // Returns at the first cycle of the period following the next boundary.
    task automatic wait_boundary();
        int k;
        k = 0;
        @(negedge clk);
        while (!period_tick && k < 1100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1100) begin
            n_chk++;
            n_fail++;
            $display("FAIL boundary_wait: no period_tick within %0d cycles", k);
        end
        @(negedge clk);
    endtask

    task automatic fill_lut(input logic [7:0] v);
        for (int i = 0; i < 256; i++) lut_mem[i] = v;
    endtask

    int exp_duty_a [6] = '{0, 0, 2, 4, 6, 8};
    int exp_addr_a [6] = '{0, 254, 255, 0, 1, 2};
    int exp_duty_d [4] = '{11, 11, 7, 0};
    int exp_duty_u [8] = '{0, 0, 3, 7, 7, 3, 3, 7};
    int hi;
    int k;

    initial begin
        fill_lut(8'd128);
        phase_step = 32'hFE00_0000;
        amp = 8'd4;
        #1 rst = 1'b1;
        #1 chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_duty", 32'(duty), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_lut_rd", 32'(lut_rd), 0);
        chk("rst_tick", 32'(period_tick), 0);
        #2 rst = 1'b0;
        start = 1'b1;

        // Ramp to amp=4 while the phase steps 254, 255, wrap to 0, 1.
        for (int b = 0; b < 6; b++) begin
            wait_boundary();
            if (b == 0) begin
                start = 1'b0;
                phase_step = 32'h0100_0000;
            end
            chk("ramp_busy", 32'(busy), 1);
            chk("ramp_duty", 32'(duty), 32'(exp_duty_a[b]));
            chk("ramp_addr", 32'(lut_addr), 32'(exp_addr_a[b]));
        end

        // Full-scale sample and gain.
        amp = 8'd255;
        fill_lut(8'd255);
        wait_boundary();
        chk("gain4_duty", 32'(duty), 15);
        wait_boundary();
        chk("full_duty", 32'(duty), 1016);
        hi = 0;
        for (int i = 0; i < 1024; i++) begin
            if (pwm_out) hi++;
            @(negedge clk);
        end
        chk("full_pwm_high_count", 32'(hi), 1016);

        // Start and stop together in RUN: stop wins, gain 3 ramps out in 3 periods.
        amp = 8'd3;
        wait_boundary();
        start = 1'b1;
        stop = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_boundary();
            chk("down_busy", 32'(busy), 32'(b < 3));
            chk("down_duty", 32'(duty), 32'(exp_duty_d[b]));
        end
        chk("idle_addr", 32'(lut_addr), 0);
        chk("idle_pwm", 32'(pwm_out), 0);
        start = 1'b0;
        stop = 1'b0;

        // Stop during the ramp-up, then restart from the current gain.
        amp = 8'd10;
        start = 1'b1;
        for (int b = 0; b < 8; b++) begin
            wait_boundary();
            chk("updown_busy", 32'(busy), 1);
            chk("updown_duty", 32'(duty), 32'(exp_duty_u[b]));
            case (b)
                0: start = 1'b0;
                2: stop = 1'b1;
                3: stop = 1'b0;
                4: start = 1'b1;
                5: start = 1'b0;
                default: ;
            endcase
        end

        // Randomised inputs, LUT contents and change times.
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < 256; i++) lut_mem[i] = 8'($urandom);
            amp = 8'($urandom_range(0, 12));
            start = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) == 0);
            phase_step = $urandom;
            repeat ($urandom_range(1, 1500)) @(negedge clk);
        end

        // Back to IDLE, then amp=0 start: one ramp-up period, then RUN at duty 0.
        start = 1'b0;
        stop = 1'b1;
        k = 0;
        while (busy && k < 40) begin
            wait_boundary();
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
        fill_lut(8'd255);
        stop = 1'b0;
        amp = 8'd0;
        start = 1'b1;
        wait_boundary();
        start = 1'b0;
        chk("amp0_busy", 32'(busy), 1);
        wait_boundary();
        chk("amp0_duty_enter_run", 32'(duty), 0);
        wait_boundary();
        chk("amp0_duty_run", 32'(duty), 0);
        amp = 8'd255;
        wait_boundary();
        wait_boundary();
        chk("pre_rst_duty", 32'(duty), 1016);

        // Reset pulse mid-period while pwm_out is high.
        k = 0;
        while (m.cnt != 10'd500 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk("pre_rst_pwm", 32'(pwm_out), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 0);
        chk("async_rst_duty", 32'(duty), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_lut_rd", 32'(lut_rd), 0);
        chk("async_rst_lut_addr", 32'(lut_addr), 0);
        chk("async_rst_tick", 32'(period_tick), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_tick && k < 2000);
        chk("restart_tick_delay", 32'(k), 1023);
        chk("restart_busy", 32'(busy), 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
